// File: rtl/snn_sched_pkg.sv
// Shared types and helpers for the SNN inference scheduler and its spike counter bank.
package snn_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    DONE
  } sched_state_t;

  localparam int unsigned SNN_CNT_W = 8;

  // Saturating increment; callers narrow the result back to their own counter width.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/snn_inference_scheduler_counter_bank.sv
// Bank of per-neuron saturating spike counters; clr has priority over counting.
module spike_counter_bank
  import snn_sched_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = 3,
  parameter int unsigned CNT_W       = SNN_CNT_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         en,
  input  logic [NUM_NEURONS-1:0]       spikes,
  output logic [NUM_NEURONS*CNT_W-1:0] count
);

  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  logic [CNT_W-1:0] cnt_q [NUM_NEURONS];
  logic [CNT_W-1:0] cnt_d [NUM_NEURONS];

  always_comb begin
    for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr) begin
        cnt_d[i] = '0;
      end else if (en && spikes[i]) begin
        cnt_d[i] = CNT_W'(sat_inc(32'(cnt_q[i]), CNT_MAX));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
      count[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end

endmodule

// File: rtl/snn_inference_scheduler.sv
// Sequences one SNN inference run: clear, stimulate, drain, count, report argmax winner.
// Optional SPI write lock while busy: define SNN_SCHED_WRITE_LOCK_EN.
module snn_inference_scheduler
  import snn_sched_pkg::*;
#(
  parameter int unsigned WIDTH               = 16,
  parameter int unsigned NUM_NEURONS_LAYER_2 = 3,
  parameter int unsigned CNT_W               = SNN_CNT_W,
  parameter int unsigned PIPE_LAT            = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [CNT_W-1:0]                     num_steps,
  input  logic signed [WIDTH-1:0]              stimulus,
  input  logic [NUM_NEURONS_LAYER_2-1:0]       spikes,
  output logic                                 nn_rst,
  output logic signed [WIDTH-1:0]              input_current,
  output logic                                 busy,
  output logic                                 done,
  output logic [$clog2(NUM_NEURONS_LAYER_2)-1:0] winner,
  output logic                                 no_spike,
  output logic [NUM_NEURONS_LAYER_2*CNT_W-1:0] spike_count,
  input  logic                                 cfg_wr_en_in,
  output logic                                 cfg_wr_en_out,
  output logic                                 wr_dropped
);

  localparam int unsigned WIN_W = $clog2(NUM_NEURONS_LAYER_2);
  localparam int unsigned DRN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  sched_state_t state_q, state_d;
  logic [CNT_W-1:0] steps_q, steps_d;
  logic [CNT_W-1:0] step_q, step_d;
  logic [DRN_W-1:0] drain_q, drain_d;
  logic             res_valid_q, res_valid_d;
  logic             cnt_clr;
  logic             cnt_en;
  logic signed [WIDTH-1:0] input_current_q;

  always_comb begin
    state_d     = state_q;
    steps_d     = steps_q;
    step_d      = step_q;
    drain_d     = drain_q;
    res_valid_d = res_valid_q;
    cnt_clr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          steps_d     = num_steps;
          step_d      = '0;
          cnt_clr     = 1'b1;
          res_valid_d = 1'b0;
          state_d     = CLEAR;
        end
      end
      CLEAR: begin
        step_d  = '0;
        drain_d = '0;
        if (steps_q == '0) begin
          res_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        step_d = step_q + CNT_W'(1);
        if (step_q == steps_q - CNT_W'(1)) begin
          drain_d = '0;
          if (PIPE_LAT == 0) begin
            res_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        drain_d = drain_q + DRN_W'(1);
        if (drain_q == DRN_W'(PIPE_LAT - 1)) begin
          res_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      steps_q         <= '0;
      step_q          <= '0;
      drain_q         <= '0;
      res_valid_q     <= 1'b0;
      input_current_q <= '0;
    end else begin
      state_q         <= state_d;
      steps_q         <= steps_d;
      step_q          <= step_d;
      drain_q         <= drain_d;
      res_valid_q     <= res_valid_d;
      // Loaded from the next state so the current is live for exactly the RUN cycles.
      input_current_q <= (state_d == RUN) ? stimulus : '0;
    end
  end

  assign cnt_en = (state_q == RUN) || (state_q == DRAIN);

  spike_counter_bank #(
    .NUM_NEURONS(NUM_NEURONS_LAYER_2),
    .CNT_W      (CNT_W)
  ) u_counters (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .spikes(spikes),
    .count (spike_count)
  );

  // Counts are frozen once DONE is reached, so the argmax is stable while results are valid.
  logic [CNT_W-1:0] best_cnt;
  logic [CNT_W-1:0] cur_cnt;
  logic [WIN_W-1:0] best_idx;
  logic             any_spike;

  always_comb begin
    best_cnt  = '0;
    best_idx  = '0;
    cur_cnt   = '0;
    any_spike = 1'b0;
    for (int unsigned i = 0; i < NUM_NEURONS_LAYER_2; i++) begin
      cur_cnt = spike_count[i*CNT_W +: CNT_W];
      if (cur_cnt > best_cnt) begin
        best_cnt = cur_cnt;
        best_idx = WIN_W'(i);
      end
      if (cur_cnt != '0) begin
        any_spike = 1'b1;
      end
    end
  end

  assign winner        = res_valid_q ? best_idx : '0;
  assign no_spike      = res_valid_q & ~any_spike;
  assign nn_rst        = (state_q == CLEAR);
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign input_current = input_current_q;

`ifdef SNN_SCHED_WRITE_LOCK_EN
  logic wr_dropped_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_dropped_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      wr_dropped_q <= 1'b0;
    end else if (cfg_wr_en_in && busy) begin
      wr_dropped_q <= 1'b1;
    end
  end

  assign cfg_wr_en_out = cfg_wr_en_in & ~busy;
  assign wr_dropped    = wr_dropped_q;
`else
  assign cfg_wr_en_out = cfg_wr_en_in;
  assign wr_dropped    = 1'b0;
`endif

endmodule

// File: tb/tb_snn_inference_scheduler.sv
// Randomized self-checking bench for snn_inference_scheduler against a run-level reference model.
module tb_snn_inference_scheduler;

  localparam int NN = 3;
  localparam int CW = 8;
  localparam int PL = 2;
  localparam int W  = 16;

`ifdef SNN_SCHED_WRITE_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [CW-1:0]      num_steps;
  logic signed [W-1:0] stimulus;
  logic [NN-1:0]      spikes;
  logic               nn_rst;
  logic signed [W-1:0] input_current;
  logic               busy;
  logic               done;
  logic [1:0]         winner;
  logic               no_spike;
  logic [NN*CW-1:0]   spike_count;
  logic               cfg_wr_en_in;
  logic               cfg_wr_en_out;
  logic               wr_dropped;

  int n_checks = 0;
  int n_fail   = 0;
  logic wdrop_e = 1'b0;

  snn_inference_scheduler #(
    .WIDTH              (W),
    .NUM_NEURONS_LAYER_2(NN),
    .CNT_W              (CW),
    .PIPE_LAT           (PL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .num_steps    (num_steps),
    .stimulus     (stimulus),
    .spikes       (spikes),
    .nn_rst       (nn_rst),
    .input_current(input_current),
    .busy         (busy),
    .done         (done),
    .winner       (winner),
    .no_spike     (no_spike),
    .spike_count  (spike_count),
    .cfg_wr_en_in (cfg_wr_en_in),
    .cfg_wr_en_out(cfg_wr_en_out),
    .wr_dropped   (wr_dropped)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // mode 0 random, 1 neuron1 x4, 2 neurons 0/2 tie x3, 3 silent, 4 all ones
  function automatic logic [NN-1:0] gen_spk(input int mode, input int k);
    logic [NN-1:0] s;
    case (mode)
      0: s = NN'($urandom);
      1: s = (k == 3 || k == 5 || k == 7 || k == 9) ? 3'b010 : 3'b000;
      2: s = (k >= 3 && k <= 5) ? 3'b101 : 3'b000;
      4: s = '1;
      default: s = '0;
    endcase
    return s;
  endfunction

  task automatic do_run(input int n, input logic signed [W-1:0] stim, input int mode);
    int total;
    int acc[NN];
    int best;
    int exp_win;
    logic exp_ns;
    logic [63:0] exp_cnt;
    logic [NN-1:0] sp;
    logic cfg;
    total = (n == 0) ? 2 : n + PL + 2;
    foreach (acc[i]) acc[i] = 0;
    exp_cnt = '0;
    exp_win = 0;
    exp_ns  = 1'b0;
    start        = 1'b1;
    num_steps    = CW'(n);
    stimulus     = stim;
    spikes       = gen_spk(mode, 0);
    cfg_wr_en_in = 1'b0;
    @(posedge clk); #1;
    wdrop_e = 1'b0;
    for (int k = 1; k <= total; k++) begin
      check_eq("busy", 64'(busy), 64'd1);
      check_eq("nn_rst", 64'(nn_rst), 64'(k == 1));
      check_eq("input_current", 64'(input_current), (n > 0 && k >= 2 && k <= n + 1) ? 64'(stim) : 64'd0);
      check_eq("done", 64'(done), 64'(k == total));
      check_eq("wr_dropped", 64'(wr_dropped), 64'(wdrop_e));
      if (k == 1) begin
        check_eq("clr_count", 64'(spike_count), 64'd0);
        check_eq("clr_winner", 64'(winner), 64'd0);
        check_eq("clr_no_spike", 64'(no_spike), 64'd0);
      end
      if (k == total) begin
        best = -1;
        exp_ns = 1'b1;
        for (int i = 0; i < NN; i++) begin
          if (acc[i] > 255) acc[i] = 255;
          exp_cnt[i*CW +: CW] = CW'(acc[i]);
          if (acc[i] > best) begin
            best = acc[i];
            exp_win = i;
          end
          if (acc[i] != 0) exp_ns = 1'b0;
        end
        check_eq("spike_count", 64'(spike_count), exp_cnt);
        check_eq("winner", 64'(winner), 64'(exp_win));
        check_eq("no_spike", 64'(no_spike), 64'(exp_ns));
      end
      sp = gen_spk(mode, k);
      spikes = sp;
      start = (mode == 0) && ($urandom_range(0, 3) == 0);
      cfg = 1'($urandom_range(0, 1));
      cfg_wr_en_in = cfg;
      #1;
      check_eq("cfg_out_busy", 64'(cfg_wr_en_out), LOCK ? 64'd0 : 64'(cfg));
      @(posedge clk); #1;
      if (n > 0 && k >= 2 && k <= n + 1 + PL) begin
        for (int i = 0; i < NN; i++) acc[i] += int'(sp[i]);
      end
      if (LOCK && cfg) wdrop_e = 1'b1;
    end
    start = 1'b0;
    check_eq("idle_busy", 64'(busy), 64'd0);
    check_eq("idle_done", 64'(done), 64'd0);
    check_eq("idle_input", 64'(input_current), 64'd0);
    check_eq("hold_count", 64'(spike_count), exp_cnt);
    check_eq("hold_winner", 64'(winner), 64'(exp_win));
    check_eq("hold_no_spike", 64'(no_spike), 64'(exp_ns));
    check_eq("idle_wr_dropped", 64'(wr_dropped), 64'(wdrop_e));
    spikes = NN'($urandom);
    cfg = 1'($urandom_range(0, 1));
    cfg_wr_en_in = cfg;
    #1;
    check_eq("cfg_out_idle", 64'(cfg_wr_en_out), 64'(cfg));
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    num_steps = '0;
    stimulus = '0;
    spikes = '0;
    cfg_wr_en_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_nn_rst", 64'(nn_rst), 64'd0);
    check_eq("rst_input", 64'(input_current), 64'd0);
    check_eq("rst_count", 64'(spike_count), 64'd0);
    check_eq("rst_winner", 64'(winner), 64'd0);
    check_eq("rst_no_spike", 64'(no_spike), 64'd0);
    check_eq("rst_wr_dropped", 64'(wr_dropped), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_run(10, 16'sd100, 1);
    do_run(8, -16'sd37, 2);
    do_run(6, 16'sd5, 3);
    do_run(255, 16'sd1234, 4);
    do_run(0, 16'sd999, 0);
    for (int r = 0; r < 20; r++) begin
      do_run(int'($urandom_range(0, 20)), W'($urandom), 0);
    end

    // Reset asserted in RUN step 5 of a run that has accumulated spikes.
    start = 1'b1;
    num_steps = CW'(10);
    stimulus = 16'sd77;
    spikes = '1;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_wr_en_in = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    cfg_wr_en_in = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    wdrop_e = 1'b0;
    check_eq("mid_rst_busy", 64'(busy), 64'd0);
    check_eq("mid_rst_input", 64'(input_current), 64'd0);
    check_eq("mid_rst_count", 64'(spike_count), 64'd0);
    check_eq("mid_rst_done", 64'(done), 64'd0);
    check_eq("mid_rst_nn_rst", 64'(nn_rst), 64'd0);
    check_eq("mid_rst_winner", 64'(winner), 64'd0);
    check_eq("mid_rst_no_spike", 64'(no_spike), 64'd0);
    check_eq("mid_rst_wr_dropped", 64'(wr_dropped), 64'd0);
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      check_eq("post_rst_done", 64'(done), 64'd0);
      check_eq("post_rst_busy", 64'(busy), 64'd0);
      check_eq("post_rst_count", 64'(spike_count), 64'd0);
    end
    spikes = '0;
    do_run(4, 16'sd3, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/snn_inference_scheduler.md
# snn_inference_scheduler

Sequences one inference run of the two-layer spiking network. On `start` it clears the network, drives a stimulus current for a programmed number of timesteps, and counts layer-2 output spikes per neuron. It then reports the winning neuron and a done pulse. It sits between the host-side control logic and `fully_connected_neural_network`. It also gates SPI configuration writes so that weights and thresholds cannot change mid-run.

## Interface
Parameters:
- `WIDTH`, 16, stimulus/current width (signed)
- `NUM_NEURONS_LAYER_2`, 3, number of output neurons counted
- `CNT_W`, 8, width of timestep counter and of each spike counter
- `PIPE_LAT`, 2, cycles from `input_current` change to the corresponding `spikes` change

Ports:
- `clk`  in  1  sole clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  run request; honoured only in IDLE
- `num_steps`  in  CNT_W  timesteps per run; latched on accepted `start`
- `stimulus`  in  WIDTH signed  current applied during the run; sampled every RUN cycle
- `spikes`  in  NUM_NEURONS_LAYER_2  layer-2 spike vector from the network
- `nn_rst`  out  1  network state clear; reset 0
- `input_current`  out  WIDTH signed  to the network; reset 0
- `busy`  out  1  high from the CLEAR state through the DONE state; reset 0
- `done`  out  1  one-cycle pulse at end of run; reset 0
- `winner`  out  $clog2(NUM_NEURONS_LAYER_2)  index of the neuron with the most spikes; reset 0
- `no_spike`  out  1  no neuron spiked during the run; reset 0
- `spike_count`  out  NUM_NEURONS_LAYER_2*CNT_W  packed per-neuron counts, neuron 0 in LSBs; reset 0
- `cfg_wr_en_in`  in  1  write enable from the SPI slave
- `cfg_wr_en_out`  out  1  write enable to the register file; reset 0
- `wr_dropped`  out  1  sticky flag: a write was blocked; reset 0

## Operation
- FSM states: IDLE → CLEAR → RUN → DRAIN → DONE → IDLE.
- IDLE:
  - `start` = 1 latches `num_steps`, zeroes the counters and goes to CLEAR.
  - `start` in any other state is ignored.
- CLEAR (1 cycle):
  - `nn_rst` = 1 and `input_current` = 0.
  - Goes to RUN, or to DONE if the latched `num_steps` = 0.
- RUN:
  - `input_current` = `stimulus` (registered).
  - Step counter increments once per cycle; leaves RUN after exactly `num_steps` cycles.
- DRAIN:
  - Lasts exactly `PIPE_LAT` cycles with `input_current` = 0.
  - Counting continues so that spikes caused by the last RUN cycles are captured.
- Counting:
  - Active in RUN and DRAIN only; each counter adds its `spikes[i]` bit per cycle.
  - Counters saturate at 2^CNT_W−1 and never wrap.
- DONE (1 cycle):
  - `done` = 1.
  - `winner` is the lowest index holding the maximum count.
  - `no_spike` = 1 when all counts are 0; `winner` = 0 in that case.
- Results:
  - `spike_count`, `winner` and `no_spike` hold their values until the next accepted `start`.
  - They are cleared on entry to CLEAR.
- Reset mid-run: returns to IDLE in the same edge, and every output goes to its reset value.

## Timing
- `start` sampled at edge t:
  - CLEAR at t+1.
  - RUN from t+2 through t+1+N.
  - DRAIN from t+2+N through t+1+N+PIPE_LAT.
  - `done` at t+2+N+PIPE_LAT.
  - IDLE at t+3+N+PIPE_LAT.
- Total latency from `start` to `done` is N+PIPE_LAT+2 cycles.
- With N = 0, `done` comes at t+2.
- A new `start` is accepted in the first IDLE cycle after DONE.
- `start` coincident with `done` is ignored.
- `spike_count`, `winner` and `no_spike` are valid in the `done` cycle.
- `cfg_wr_en_out` is combinational from `cfg_wr_en_in` and state. It has zero added latency, matching the direct SPI-to-register-file connection it replaces.

## Configuration
- `SNN_SCHED_WRITE_LOCK_EN` defined:
  - `cfg_wr_en_out` = `cfg_wr_en_in` & !`busy`.
  - `wr_dropped` sets when `cfg_wr_en_in` & `busy`.
  - `wr_dropped` clears on reset or on an accepted `start`.
- Undefined:
  - `cfg_wr_en_out` = `cfg_wr_en_in` always.
  - `wr_dropped` is tied to 0.

## Structure
- Package `snn_sched_pkg` holds:
  - the state enum `sched_state_t` (IDLE, CLEAR, RUN, DRAIN, DONE);
  - the `CNT_W` default;
  - a `sat_inc` function for the saturating increment.
- Sub-module `spike_counter_bank` holds NUM_NEURONS_LAYER_2 saturating counters, with `clr`, `en` and `spikes` inputs and a packed count output. The argmax logic stays in the scheduler.

## Test plan
- **Basic run:** reset, then `start` with `num_steps` = 10, `stimulus` = 100, and neuron 1 spiking on 4 cycles while the others are silent → `done` 14 cycles after `start`; `spike_count` = {0,4,0}; `winner` = 1; `no_spike` = 0.
- **Tie and silence:**
  - Neurons 0 and 2 each spike 3 times → `winner` = 0.
  - No spikes at all → `no_spike` = 1 and `winner` = 0.
- **Saturation:** `CNT_W` = 8, `num_steps` = 255, `PIPE_LAT` = 2, `spikes` held at all ones → every count = 255 with no wrap.
- **Zero steps and busy start:**
  - `num_steps` = 0 → `done` 2 cycles after `start`; counts 0; `input_current` stays 0.
  - `start` asserted during RUN → ignored; the run completes unchanged.
- **Write lock (macro defined):** `cfg_wr_en_in` pulsed in RUN → `cfg_wr_en_out` stays 0 and `wr_dropped` = 1. The same pulse in IDLE passes through. Without the macro, both pulses pass through.
- **Reset mid-run:** `rst` asserted in RUN step 5 → the next cycle shows `busy` = 0, `input_current` = 0, counts 0, and no `done` pulse.
